// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared constants for the instruction sequencer
// Purpose: opcode values, FSM state encoding, instruction field positions and
//          the legality check shared by the sequencer and its ALU.
// Ports:   none (package).
package seq_pkg;

  localparam int REG_AW = 4;

  // Instruction field bit positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS_HI  = 20;
  localparam int RS_LO  = 16;
  localparam int RT_HI  = 15;
  localparam int RT_LO  = 11;
  localparam int OFS_HI = 10;
  localparam int OFS_LO = 0;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_XOR  = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd4;
  localparam logic [5:0] OP_SHR  = 6'd5;
  localparam logic [5:0] OP_SRA  = 6'd6;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_e;

  // Register fields are 5 bits wide but only 16 registers exist, so bit 4 set
  // on any of them makes the word illegal.
  function automatic logic instr_legal(input logic [31:0] ir);
    return (ir[OPC_HI:OPC_LO] <= OP_SRA) && !ir[RD_HI] && !ir[RS_HI] && !ir[RT_HI];
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - instruction handshake, retire status and debug read bus
// Purpose: bundles the instruction valid/ready handshake, retire outputs and
//          the debug bank read port.
// Ports:   master = instruction source / observer, slave = sequencer.
//          instr_valid, instr, dbg_addr : master -> slave
//          instr_ready, done, err, result, carry, dbg_data : slave -> master
interface instr_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] result;
  logic              carry;
  logic [3:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output instr_valid, instr, dbg_addr,
    input  instr_ready, done, err, result, carry, dbg_data
  );

  modport slave (
    input  instr_valid, instr, dbg_addr,
    output instr_ready, done, err, result, carry, dbg_data
  );
endinterface

// File: rtl/instr_sequencer_alu.sv
// rtl/instr_sequencer_alu.sv - combinational ALU used by the sequencer
// Purpose: computes y and carry for ADD/SUB/AND/XOR/ADDI/SHR/SRA.
// Ports:   op (6b opcode), a/b (operands), offset (11b immediate),
//          y (result), carry (carry for ADD/ADDI, borrow for SUB, else 0).
module seq_alu
  import seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [10:0]       offset,
  output logic [DATA_W-1:0] y,
  output logic              carry
);

  logic [DATA_W:0]          w_sum;
  logic [DATA_W:0]          w_diff;
  logic [DATA_W:0]          w_addi;
  logic [DATA_W-1:0]        w_ofs_ext;
  logic signed [DATA_W-1:0] w_sra;

  assign w_ofs_ext = {{(DATA_W-11){offset[10]}}, offset};
  assign w_sum     = {1'b0, a} + {1'b0, b};
  // Top bit of the zero-extended difference is the borrow (a < b unsigned).
  assign w_diff    = {1'b0, a} - {1'b0, b};
  assign w_addi    = {1'b0, a} + {1'b0, w_ofs_ext};
  assign w_sra     = $signed(a) >>> offset[4:0];

  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op)
      OP_ADD:  begin y = w_sum[DATA_W-1:0];  carry = w_sum[DATA_W];  end
      OP_SUB:  begin y = w_diff[DATA_W-1:0]; carry = w_diff[DATA_W]; end
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      OP_ADDI: begin y = w_addi[DATA_W-1:0]; carry = w_addi[DATA_W]; end
      OP_SHR:  y = a >> offset[4:0];
      OP_SRA:  y = w_sra;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - four-state instruction sequencer over a 16x32 register bank
// Purpose: accepts an instruction word, decodes it, reads two operands,
//          runs the ALU and writes the result back (IDLE->DECODE->EXECUTE->WRITEBACK).
// Ports:   clk, rst (async active-high), bus (instr_sequencer_if.slave):
//          instruction handshake, done/err retire pulses, result/carry,
//          combinational debug read of the bank.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 16
) (
  input logic                clk,
  input logic                rst,
  instr_sequencer_if.slave   bus
);

  state_e            r_state;
  logic [31:0]       r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_illegal;
  logic              r_done;
  logic              r_err;
  logic [DATA_W-1:0] r_result;
  logic              r_carry;
  logic [DATA_W-1:0] r_bank [REG_COUNT];

  logic [REG_AW-1:0] w_rd_idx;
  logic [REG_AW-1:0] w_rs_idx;
  logic [REG_AW-1:0] w_rt_idx;
  logic [DATA_W-1:0] w_alu_y;
  logic              w_alu_c;

  assign w_rd_idx = r_ir[RD_LO+REG_AW-1:RD_LO];
  assign w_rs_idx = r_ir[RS_LO+REG_AW-1:RS_LO];
  assign w_rt_idx = r_ir[RT_LO+REG_AW-1:RT_LO];

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (r_ir[OPC_HI:OPC_LO]),
    .a      (r_a),
    .b      (r_b),
    .offset (r_ir[OFS_HI:OFS_LO]),
    .y      (w_alu_y),
    .carry  (w_alu_c)
  );

  // Gated by rst so ready is low for the whole reset and high in the very
  // first IDLE cycle after release.
  assign bus.instr_ready = (r_state == ST_IDLE) && !rst;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.result      = r_result;
  assign bus.carry       = r_carry;
  assign bus.dbg_data    = r_bank[bus.dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_illegal <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_result  <= '0;
      r_carry   <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) r_bank[i] <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            r_ir    <= bus.instr;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_a       <= r_bank[w_rs_idx];
          r_b       <= r_bank[w_rt_idx];
          r_illegal <= !instr_legal(r_ir);
          r_state   <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          // Retire outputs are registered here so they are visible during WRITEBACK.
          r_done   <= 1'b1;
          r_err    <= r_illegal;
          r_result <= r_illegal ? '0 : w_alu_y;
          r_carry  <= r_illegal ? 1'b0 : w_alu_c;
          r_state  <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          if (!r_illegal) r_bank[w_rd_idx] <= r_result;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
module tb_instr_sequencer;
  import seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_sequencer_if bus ();

  instr_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] mdl [16];

  typedef struct {
    logic [31:0] w;
    logic [31:0] res;
    logic        c;
    logic        e;
    string       nm;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int rt, input int off);
    return {6'(op), 5'(rd), 5'(rs), 5'(rt), 11'(off)};
  endfunction

  // Reference model: evaluates one word against the bank copy and commits it.
  task automatic model(input logic [31:0] w, output logic [31:0] res, output logic c, output logic e);
    int op, rd, rs, rt, off, sh, soff;
    logic [31:0] a, b;
    longint s;
    op = int'(w[31:26]); rd = int'(w[25:21]); rs = int'(w[20:16]);
    rt = int'(w[15:11]); off = int'(w[10:0]); sh = off % 32;
    e = (op > 6) || (rd > 15) || (rs > 15) || (rt > 15);
    res = 32'h0;
    c = 1'b0;
    if (!e) begin
      a = mdl[rs];
      b = mdl[rt];
      case (op)
        0: begin s = longint'(a) + longint'(b); res = s[31:0]; c = (s >= 64'h1_0000_0000); end
        1: begin res = a - b; c = (a < b); end
        2: res = a & b;
        3: res = a ^ b;
        4: begin
          soff = (off >= 1024) ? off - 2048 : off;
          s = longint'(a) + ((soff < 0) ? longint'(soff) + 64'h1_0000_0000 : longint'(soff));
          res = s[31:0];
          c = (s >= 64'h1_0000_0000);
        end
        5: res = a >> sh;
        default: res = a[31] ? ~((~a) >> sh) : (a >> sh);
      endcase
      mdl[rd] = res;
    end
  endtask

  // Issues one word and checks handshake timing, retire outputs and the bank.
  task automatic run(input logic [31:0] w, input logic [31:0] er, input logic ec, input logic ee, input string nm);
    int t;
    @(negedge clk);
    t = 0;
    while (!bus.instr_ready && t < 20) begin @(negedge clk); t++; end
    chk({nm, " ready_idle"}, 32'(bus.instr_ready), 32'd1);
    bus.instr = w;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    chk({nm, " ready_dec"}, 32'(bus.instr_ready), 32'd0);
    chk({nm, " done_dec"}, 32'(bus.done), 32'd0);
    bus.instr = $urandom;
    bus.instr_valid = 1'($urandom % 2);
    @(negedge clk);
    chk({nm, " ready_exe"}, 32'(bus.instr_ready), 32'd0);
    chk({nm, " done_exe"}, 32'(bus.done), 32'd0);
    bus.instr = $urandom;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk({nm, " done"}, 32'(bus.done), 32'd1);
    chk({nm, " err"}, 32'(bus.err), 32'(ee));
    chk({nm, " result"}, bus.result, er);
    chk({nm, " carry"}, 32'(bus.carry), 32'(ec));
    bus.dbg_addr = w[24:21];
    @(negedge clk);
    chk({nm, " done_clr"}, 32'(bus.done), 32'd0);
    chk({nm, " ready_back"}, 32'(bus.instr_ready), 32'd1);
    chk({nm, " bank_rd"}, bus.dbg_data, mdl[w[24:21]]);
  endtask

  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      n_vec++;
      if (prev_done) begin
        n_bad++;
        $display("FAIL done_consecutive: got 1, expected 0");
      end
    end
    if (bus.err === 1'b1 && bus.done !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL err_without_done: got done=%b, expected 1", bus.done);
    end
    prev_done <= (bus.done === 1'b1);
  end

  initial begin
    logic [31:0] words [3];
    logic [31:0] wexp [3];
    int acc [3];
    int k, dn;
    bit pend;
    logic [31:0] r, w;
    logic c, e;

    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.dbg_addr = '0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;

    tbl.push_back('{enc(4, 1, 0, 0, 5),      32'h5,        1'b0, 1'b0, "addi_r1_5"});
    tbl.push_back('{enc(4, 2, 0, 0, 11'h7FF), 32'hFFFFFFFF, 1'b0, 1'b0, "addi_r2_m1"});
    tbl.push_back('{enc(0, 3, 2, 1, 0),      32'h4,        1'b1, 1'b0, "add_r3"});
    tbl.push_back('{enc(1, 4, 1, 2, 0),      32'h6,        1'b1, 1'b0, "sub_r4"});
    tbl.push_back('{enc(6, 5, 2, 0, 4),      32'hFFFFFFFF, 1'b0, 1'b0, "sra_r5"});
    tbl.push_back('{enc(5, 6, 2, 0, 28),     32'h0000000F, 1'b0, 1'b0, "shr_r6"});
    tbl.push_back('{enc(3, 7, 6, 1, 0),      32'h0000000A, 1'b0, 1'b0, "xor_r7"});
    tbl.push_back('{enc(2, 8, 6, 1, 0),      32'h00000005, 1'b0, 1'b0, "and_r8"});
    tbl.push_back('{enc(7, 3, 1, 1, 0),      32'h0,        1'b0, 1'b1, "illegal_op7"});
    tbl.push_back('{enc(0, 17, 6, 1, 0),     32'h0,        1'b0, 1'b1, "illegal_rd17"});
    tbl.push_back('{enc(0, 9, 16, 1, 0),     32'h0,        1'b0, 1'b1, "illegal_rs16"});
    tbl.push_back('{enc(63, 2, 0, 0, 0),     32'h0,        1'b0, 1'b1, "illegal_op63"});
    tbl.push_back('{enc(0, 1, 1, 1, 0),      32'hA,        1'b0, 1'b0, "add_rd_eq_rs"});
    tbl.push_back('{enc(4, 9, 1, 0, 11'h400), 32'hFFFFFC0A, 1'b0, 1'b0, "addi_min_ofs"});
    tbl.push_back('{enc(1, 10, 1, 1, 0),     32'h0,        1'b0, 1'b0, "sub_self"});

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst ready", 32'(bus.instr_ready), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst err", 32'(bus.err), 32'd0);
    chk("rst result", bus.result, 32'd0);
    chk("rst carry", 32'(bus.carry), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready after release", 32'(bus.instr_ready), 32'd1);

    foreach (tbl[i]) begin
      if (!tbl[i].e) mdl[tbl[i].w[24:21]] = tbl[i].res;
      run(tbl[i].w, tbl[i].res, tbl[i].c, tbl[i].e, tbl[i].nm);
    end
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = 4'(i);
      #1;
      chk($sformatf("bank_sweep r%0d", i), bus.dbg_data, mdl[i]);
    end

    // Back-to-back with instr_valid held high
    words[0] = enc(4, 11, 0, 0, 1);   wexp[0] = 32'h1;
    words[1] = enc(4, 12, 11, 0, 2);  wexp[1] = 32'h3;
    words[2] = enc(0, 13, 12, 11, 0); wexp[2] = 32'h4;
    mdl[11] = 32'h1; mdl[12] = 32'h3; mdl[13] = 32'h4;
    acc = '{-1, -1, -1};
    k = 0; dn = 0; pend = 0;
    @(negedge clk);
    bus.instr = words[0];
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (pend) begin
        if (k < 3) bus.instr = words[k];
        else bus.instr_valid = 1'b0;
        pend = 0;
      end
      if (bus.done && dn < 3) begin
        chk($sformatf("b2b result %0d", dn), bus.result, wexp[dn]);
        dn++;
      end
      if (bus.instr_ready && bus.instr_valid && k < 3) begin
        acc[k] = i;
        k++;
        pend = 1;
      end
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) chk($sformatf("b2b accept %0d", i), 32'(acc[i]), 32'(4 * i));
    chk("b2b done count", 32'(dn), 32'd3);
    bus.dbg_addr = 4'd13;
    #1;
    chk("b2b r13", bus.dbg_data, 32'h4);

    // Randomized instructions against the model
    for (int n = 0; n < 40; n++) begin
      int op, rd, rs, rt;
      op = ($urandom % 9 == 0) ? 7 + int'($urandom % 57) : int'($urandom % 7);
      rd = int'($urandom % 16) + (($urandom % 12 == 0) ? 16 : 0);
      rs = int'($urandom % 16) + (($urandom % 12 == 0) ? 16 : 0);
      rt = int'($urandom % 16);
      w = enc(op, rd, rs, rt, int'($urandom % 2048));
      model(w, r, c, e);
      run(w, r, c, e, $sformatf("rand%0d", n));
    end

    // Reset during EXECUTE abandons the instruction
    @(negedge clk);
    bus.instr = enc(4, 9, 0, 0, 7);
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst ready", 32'(bus.instr_ready), 32'd0);
    chk("midrst done", 32'(bus.done), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst hold done", 32'(bus.done), 32'd0);
      chk("midrst hold ready", 32'(bus.instr_ready), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("midrst ready after release", 32'(bus.instr_ready), 32'd1);
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    repeat (5) begin
      @(negedge clk);
      chk("midrst no done", 32'(bus.done), 32'd0);
    end
    bus.dbg_addr = 4'd9;
    #1;
    chk("midrst r9", bus.dbg_data, 32'h0);
    bus.dbg_addr = 4'd1;
    #1;
    chk("midrst r1 cleared", bus.dbg_data, 32'h0);
    mdl[9] = 32'h7;
    run(enc(4, 9, 0, 0, 7), 32'h7, 1'b0, 1'b0, "post_rst_addi");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
